// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: register width, register count and address/word typedefs.
package riscv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xword_t;

    // Write-back payload as seen by the register file.
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        xword_t    data;
    } wb_t;

    // True when a write-back targets a real (non-x0) register equal to addr.
    function automatic logic wb_hits(input logic valid, input reg_addr_t rd,
                                     input reg_addr_t addr);
        return valid && (rd != REG_AW'(0)) && (rd == addr);
    endfunction

endpackage

// File: rtl/regfile_64_if.sv
// Register-file bus: two read ports with busy flags, issue scoreboard input, write-back.
interface regfile_64_if;
    import riscv_pkg::*;

    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    xword_t    rs1_data;
    xword_t    rs2_data;
    logic      rs1_busy;
    logic      rs2_busy;
    logic      issue_valid;
    reg_addr_t issue_rd;
    logic      wb_valid;
    reg_addr_t wb_rd;
    xword_t    wb_data;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy
    );

    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
        output rs1_data, rs2_data, rs1_busy, rs2_busy
    );

endinterface

// File: rtl/regfile_64_scoreboard.sv
// Per-register busy scoreboard: issue sets, write-back clears, issue wins on a tie.
module reg_scoreboard
    import riscv_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_valid_i,
    input  reg_addr_t issue_rd_i,
    input  logic      wb_valid_i,
    input  reg_addr_t wb_rd_i,
    input  reg_addr_t rs1_addr_i,
    input  reg_addr_t rs2_addr_i,
    output logic      rs1_busy_o,
    output logic      rs2_busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear first, then set, so a newer producer to the same rd stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) begin
            busy_d[wb_rd_i] = 1'b0;
        end
        if (issue_valid_i) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A write-back landing this cycle releases its consumers immediately.
    assign rs1_busy_o = busy_q[rs1_addr_i] && !(wb_valid_i && (wb_rd_i == rs1_addr_i));
    assign rs2_busy_o = busy_q[rs2_addr_i] && !(wb_valid_i && (wb_rd_i == rs2_addr_i));

endmodule

// File: rtl/regfile_64.sv
// 32 x 64-bit integer register file with write-back bypass and busy scoreboard.
module regfile_64
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    regfile_64_if.slave  rf
);

    xword_t regs_q [NREG];
    xword_t rs1_data;
    xword_t rs2_data;
    logic   rs1_busy;
    logic   rs2_busy;

    // Data array; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf.wb_valid && (rf.wb_rd != REG_AW'(0))) begin
            regs_q[rf.wb_rd] <= rf.wb_data;
        end
    end

    // Read muxes with same-cycle write-back bypass.
    always_comb begin
        rs1_data = regs_q[rf.rs1_addr];
        rs2_data = regs_q[rf.rs2_addr];
        if (wb_hits(rf.wb_valid, rf.wb_rd, rf.rs1_addr)) begin
            rs1_data = rf.wb_data;
        end
        if (wb_hits(rf.wb_valid, rf.wb_rd, rf.rs2_addr)) begin
            rs2_data = rf.wb_data;
        end
        if (rf.rs1_addr == REG_AW'(0)) begin
            rs1_data = '0;
        end
        if (rf.rs2_addr == REG_AW'(0)) begin
            rs2_data = '0;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (rf.issue_valid),
        .issue_rd_i    (rf.issue_rd),
        .wb_valid_i    (rf.wb_valid),
        .wb_rd_i       (rf.wb_rd),
        .rs1_addr_i    (rf.rs1_addr),
        .rs2_addr_i    (rf.rs2_addr),
        .rs1_busy_o    (rs1_busy),
        .rs2_busy_o    (rs2_busy)
    );

    assign rf.rs1_data = rs1_data;
    assign rf.rs2_data = rs2_data;
    assign rf.rs1_busy = rs1_busy;
    assign rf.rs2_busy = rs2_busy;

endmodule

// File: tb/tb_regfile_64.sv
// Directed bench for regfile_64: reset, x0, write/read, bypass, scoreboard, mid-run reset.
module tb_regfile_64;
    import riscv_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    regfile_64_if rf_if ();

    regfile_64 dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.issue_valid = 1'b0;
        rf_if.issue_rd    = '0;
        rf_if.wb_valid    = 1'b0;
        rf_if.wb_rd       = '0;
        rf_if.wb_data     = '0;
    endtask

    task automatic wb(input reg_addr_t rd, input xword_t data);
        rf_if.wb_valid = 1'b1;
        rf_if.wb_rd    = rd;
        rf_if.wb_data  = data;
    endtask

    task automatic issue(input reg_addr_t rd);
        rf_if.issue_valid = 1'b1;
        rf_if.issue_rd    = rd;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        rf_if.rs1_addr = '0;
        rf_if.rs2_addr = '0;
        idle();

        // Reset, then sweep every address on both ports.
        step();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rf_if.rs1_addr = reg_addr_t'(a);
            rf_if.rs2_addr = reg_addr_t'(31 - a);
            #1;
            check_eq("reset_rs1_data", rf_if.rs1_data, 64'h0);
            check_eq("reset_rs2_data", rf_if.rs2_data, 64'h0);
            check_eq("reset_rs1_busy", 64'(rf_if.rs1_busy), 64'h0);
            check_eq("reset_rs2_busy", 64'(rf_if.rs2_busy), 64'h0);
        end

        // x0 write is dropped and never bypassed.
        rf_if.rs1_addr = 5'd0;
        wb(5'd0, 64'hDEAD);
        #1;
        check_eq("x0_bypass", rf_if.rs1_data, 64'h0);
        step();
        idle();
        #1;
        check_eq("x0_after_write", rf_if.rs1_data, 64'h0);

        // Write x5, read it next cycle.
        wb(5'd5, 64'h7FFF_FFFF_FFFF_FFFF);
        step();
        idle();
        rf_if.rs1_addr = 5'd5;
        rf_if.rs2_addr = 5'd6;
        #1;
        check_eq("read_x5", rf_if.rs1_data, 64'h7FFF_FFFF_FFFF_FFFF);
        check_eq("read_x6_untouched", rf_if.rs2_data, 64'h0);

        // Same-cycle bypass on port 2, then the array holds it.
        rf_if.rs2_addr = 5'd7;
        wb(5'd7, 64'h1234);
        #1;
        check_eq("bypass_x7", rf_if.rs2_data, 64'h1234);
        check_eq("bypass_no_leak_rs1", rf_if.rs1_data, 64'h7FFF_FFFF_FFFF_FFFF);
        step();
        idle();
        #1;
        check_eq("array_x7", rf_if.rs2_data, 64'h1234);

        // Scoreboard: issue x3, busy appears after the edge.
        rf_if.rs1_addr = 5'd3;
        issue(5'd3);
        #1;
        check_eq("busy_not_yet", 64'(rf_if.rs1_busy), 64'h0);
        step();
        idle();
        #1;
        check_eq("busy_set_x3", 64'(rf_if.rs1_busy), 64'h1);
        check_eq("busy_x7_clear", 64'(rf_if.rs2_busy), 64'h0);

        // Write-back releases the consumer combinationally.
        wb(5'd3, 64'h55);
        #1;
        check_eq("wb_unstall_x3", 64'(rf_if.rs1_busy), 64'h0);
        check_eq("wb_bypass_x3", rf_if.rs1_data, 64'h55);
        step();
        idle();
        #1;
        check_eq("busy_cleared_x3", 64'(rf_if.rs1_busy), 64'h0);
        check_eq("array_x3", rf_if.rs1_data, 64'h55);

        // Issue and write-back to the same rd: issue wins, data still written.
        issue(5'd3);
        wb(5'd3, 64'h66);
        #1;
        check_eq("tie_busy_masked", 64'(rf_if.rs1_busy), 64'h0);
        step();
        idle();
        #1;
        check_eq("tie_busy_after", 64'(rf_if.rs1_busy), 64'h1);
        check_eq("tie_data_x3", rf_if.rs1_data, 64'h66);

        // Issue to x0 never marks it busy.
        issue(5'd0);
        step();
        idle();
        rf_if.rs1_addr = 5'd0;
        #1;
        check_eq("x0_never_busy", 64'(rf_if.rs1_busy), 64'h0);

        // Reset mid-operation: busy x1, x2; x1 = 0xFF.
        issue(5'd1);
        step();
        idle();
        issue(5'd2);
        wb(5'd1, 64'hFF);
        step();
        idle();
        rf_if.rs1_addr = 5'd1;
        rf_if.rs2_addr = 5'd2;
        #1;
        check_eq("pre_rst_x1_data", rf_if.rs1_data, 64'hFF);
        check_eq("pre_rst_x1_busy", 64'(rf_if.rs1_busy), 64'h0);
        check_eq("pre_rst_x2_busy", 64'(rf_if.rs2_busy), 64'h1);
        rst = 1'b1;
        wb(5'd2, 64'hABC);
        step();
        rst = 1'b0;
        idle();
        #1;
        check_eq("post_rst_x1_data", rf_if.rs1_data, 64'h0);
        check_eq("post_rst_x2_data", rf_if.rs2_data, 64'h0);
        check_eq("post_rst_x2_busy", 64'(rf_if.rs2_busy), 64'h0);
        rf_if.rs1_addr = 5'd3;
        rf_if.rs2_addr = 5'd5;
        #1;
        check_eq("post_rst_x3_busy", 64'(rf_if.rs1_busy), 64'h0);
        check_eq("post_rst_x3_data", rf_if.rs1_data, 64'h0);
        check_eq("post_rst_x5_data", rf_if.rs2_data, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
